// File: rtl/rsa_cmd_responder.sv
// Command/handshake responder between the ARM port bundle and the Montgomery/exponentiation core.
// Decodes ARM commands, loads 1024-bit operands, launches the core and returns its result.
module rsa_cmd_responder (
    input  logic          clk,
    input  logic          resetn,
    input  logic [31:0]   arm_to_fpga_cmd,
    input  logic          arm_to_fpga_cmd_valid,
    output logic          fpga_to_arm_done,
    input  logic          fpga_to_arm_done_read,
    input  logic          arm_to_fpga_data_valid,
    output logic          arm_to_fpga_data_ready,
    input  logic [1023:0] arm_to_fpga_data,
    output logic          fpga_to_arm_data_valid,
    input  logic          fpga_to_arm_data_ready,
    output logic [1023:0] fpga_to_arm_data,
    output logic [1023:0] reg_mod,
    output logic [1023:0] reg_rsq,
    output logic [1023:0] reg_exp,
    output logic          core_start,
    output logic          core_mode,
    input  logic          core_done,
    input  logic [1023:0] core_result,
    output logic [3:0]    leds
);

    localparam logic [31:0] CMD_COMPUTE_EXP  = 32'd0;
    localparam logic [31:0] CMD_COMPUTE_MONT = 32'd1;
    localparam logic [31:0] CMD_READ_MOD     = 32'd2;
    localparam logic [31:0] CMD_READ_RSQ     = 32'd3;
    localparam logic [31:0] CMD_READ_EXP     = 32'd4;
    localparam logic [31:0] CMD_WRITE        = 32'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RX    = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_TX    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_reg;
    logic            err_reg;
    logic [1:0]      sel_reg;
    logic            done_reg;
    logic            data_ready_reg;
    logic            tx_valid_reg;
    logic            core_start_reg;
    logic            core_mode_reg;
    logic [1023:0]   result_reg;
    logic [2:0]      cap_en;

    // Operand select index: 0 = modulus, 1 = R^2/operand, 2 = exponent.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_opnd
            logic [1023:0] operand_reg;

            assign cap_en[gi] = (state_reg == S_RX) && arm_to_fpga_data_valid
                                && (sel_reg == 2'(gi));

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    operand_reg <= '0;
                end else if (cap_en[gi]) begin
                    operand_reg <= arm_to_fpga_data;
                end
            end
        end
    endgenerate

    assign reg_mod = g_opnd[0].operand_reg;
    assign reg_rsq = g_opnd[1].operand_reg;
    assign reg_exp = g_opnd[2].operand_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= S_IDLE;
            err_reg        <= 1'b0;
            sel_reg        <= 2'd0;
            done_reg       <= 1'b0;
            data_ready_reg <= 1'b0;
            tx_valid_reg   <= 1'b0;
            core_start_reg <= 1'b0;
            core_mode_reg  <= 1'b0;
            result_reg     <= '0;
        end else begin
            data_ready_reg <= 1'b0;
            core_start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (arm_to_fpga_cmd_valid) begin
                        err_reg <= 1'b0;
                        case (arm_to_fpga_cmd)
                            CMD_READ_MOD, CMD_READ_RSQ, CMD_READ_EXP: begin
                                sel_reg   <= arm_to_fpga_cmd[1:0] - 2'd2;
                                state_reg <= S_RX;
                            end
                            CMD_COMPUTE_EXP, CMD_COMPUTE_MONT: begin
                                core_mode_reg  <= arm_to_fpga_cmd[0];
                                core_start_reg <= 1'b1;
                                state_reg      <= S_START;
                            end
                            CMD_WRITE: begin
                                state_reg <= S_TX;
                            end
                            default: begin
                                err_reg   <= 1'b1;
                                state_reg <= S_DONE;
                            end
                        endcase
                    end
                end
                S_RX: begin
                    if (arm_to_fpga_data_valid) begin
                        data_ready_reg <= 1'b1;
                        state_reg      <= S_DONE;
                    end
                end
                S_START: begin
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        result_reg <= core_result;
                        state_reg  <= S_DONE;
                    end
                end
                S_TX: begin
                    // Valid is raised on the first TX cycle; ready only counts once valid is visible.
                    if (tx_valid_reg && fpga_to_arm_data_ready) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= S_DONE;
                    end else begin
                        tx_valid_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    // An acknowledge only counts once done is actually visible to the ARM.
                    if (done_reg && fpga_to_arm_done_read) begin
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign fpga_to_arm_done       = done_reg;
    assign arm_to_fpga_data_ready = data_ready_reg;
    assign fpga_to_arm_data_valid = tx_valid_reg;
    assign fpga_to_arm_data       = result_reg;
    assign core_start             = core_start_reg;
    assign core_mode              = core_mode_reg;
    assign leds                   = {err_reg, state_reg};

endmodule

// File: tb/tb_rsa_cmd_responder.sv
// Directed and randomized bench for rsa_cmd_responder against a transaction-level model.
module tb_rsa_cmd_responder;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   arm_to_fpga_cmd = '0;
    logic          arm_to_fpga_cmd_valid = 1'b0;
    logic          fpga_to_arm_done;
    logic          fpga_to_arm_done_read = 1'b0;
    logic          arm_to_fpga_data_valid = 1'b0;
    logic          arm_to_fpga_data_ready;
    logic [1023:0] arm_to_fpga_data = '0;
    logic          fpga_to_arm_data_valid;
    logic          fpga_to_arm_data_ready = 1'b0;
    logic [1023:0] fpga_to_arm_data;
    logic [1023:0] reg_mod, reg_rsq, reg_exp;
    logic          core_start, core_mode;
    logic          core_done = 1'b0;
    logic [1023:0] core_result = '0;
    logic [3:0]    leds;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    // Reference model: operand registers (0 mod, 1 rsq, 2 exp), result and error flag.
    logic [1023:0] m_reg [3];
    logic [1023:0] m_result;
    logic          m_err;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_RX = 3'd1, ST_START = 3'd2,
                           ST_WAIT = 3'd3, ST_TX = 3'd4, ST_DONE = 3'd5;

    rsa_cmd_responder dut (
        .clk(clk), .resetn(resetn),
        .arm_to_fpga_cmd(arm_to_fpga_cmd), .arm_to_fpga_cmd_valid(arm_to_fpga_cmd_valid),
        .fpga_to_arm_done(fpga_to_arm_done), .fpga_to_arm_done_read(fpga_to_arm_done_read),
        .arm_to_fpga_data_valid(arm_to_fpga_data_valid), .arm_to_fpga_data_ready(arm_to_fpga_data_ready),
        .arm_to_fpga_data(arm_to_fpga_data),
        .fpga_to_arm_data_valid(fpga_to_arm_data_valid), .fpga_to_arm_data_ready(fpga_to_arm_data_ready),
        .fpga_to_arm_data(fpga_to_arm_data),
        .reg_mod(reg_mod), .reg_rsq(reg_rsq), .reg_exp(reg_exp),
        .core_start(core_start), .core_mode(core_mode),
        .core_done(core_done), .core_result(core_result),
        .leds(leds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_start === 1'b1) start_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs[255:0], exp[255:0]);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, " reg_mod"}, reg_mod, m_reg[0]);
        chk({tag, " reg_rsq"}, reg_rsq, m_reg[1]);
        chk({tag, " reg_exp"}, reg_exp, m_reg[2]);
        chk({tag, " result"}, fpga_to_arm_data, m_result);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_reg[i] = '0;
        m_result = '0;
        m_err = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " done"}, fpga_to_arm_done, 0);
        chk({tag, " ready"}, arm_to_fpga_data_ready, 0);
        chk({tag, " tx_valid"}, fpga_to_arm_data_valid, 0);
        chk({tag, " core_start"}, core_start, 0);
        chk({tag, " core_mode"}, core_mode, 0);
        chk({tag, " leds"}, leds, 4'h0);
        check_regs(tag);
    endtask

    // Called at a falling edge; returns one falling edge after the decode edge.
    task automatic send_cmd(input logic [31:0] c);
        arm_to_fpga_cmd = c;
        arm_to_fpga_cmd_valid = 1'b1;
        @(negedge clk);
        arm_to_fpga_cmd_valid = 1'b0;
        arm_to_fpga_cmd = $urandom;
    endtask

    task automatic ack(input string tag);
        fpga_to_arm_done_read = 1'b1;
        @(negedge clk);
        fpga_to_arm_done_read = 1'b0;
        chk({tag, " done_low_after_ack"}, fpga_to_arm_done, 0);
        chk({tag, " leds_idle"}, leds, {m_err, ST_IDLE});
    endtask

    task automatic do_read(input int code, input logic [1023:0] val, input int gap);
        $display("txn READ code=%0d gap=%0d data_lo=%h", code, gap, val[31:0]);
        send_cmd(code);
        m_err = 1'b0;
        chk("rx leds", leds, {1'b0, ST_RX});
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            chk("rx ready_idle", arm_to_fpga_data_ready, 0);
        end
        arm_to_fpga_data = val;
        arm_to_fpga_data_valid = 1'b1;
        @(negedge clk);
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data = rand1024();
        m_reg[code-2] = val;
        chk("rx ready_pulse", arm_to_fpga_data_ready, 1);
        chk("rx done_early", fpga_to_arm_done, 0);
        check_regs("rx capture");
        @(negedge clk);
        chk("rx ready_fall", arm_to_fpga_data_ready, 0);
        chk("rx done_rise", fpga_to_arm_done, 1);
        chk("rx leds_done", leds, {1'b0, ST_DONE});
        // Stray data outside RX must be neither captured nor acknowledged.
        arm_to_fpga_data_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rx stray_ready", arm_to_fpga_data_ready, 0);
            chk("rx done_hold", fpga_to_arm_done, 1);
        end
        arm_to_fpga_data_valid = 1'b0;
        check_regs("rx stray");
        ack("rx");
    endtask

    task automatic do_compute(input int code, input logic [1023:0] val, input int lat, input bit poke);
        int s0;
        s0 = start_cnt;
        $display("txn COMPUTE code=%0d lat=%0d poke=%0d res_lo=%h", code, lat, poke, val[31:0]);
        send_cmd(code);
        m_err = 1'b0;
        chk("cmp start_high", core_start, 1);
        chk("cmp mode", core_mode, code[0]);
        chk("cmp leds_start", leds, {1'b0, ST_START});
        @(negedge clk);
        chk("cmp start_low", core_start, 0);
        chk("cmp leds_wait", leds, {1'b0, ST_WAIT});
        for (int i = 0; i < lat; i++) begin
            if (poke && i == lat / 2) begin
                arm_to_fpga_cmd = 32'd2;
                arm_to_fpga_cmd_valid = 1'b1;
            end
            @(negedge clk);
            arm_to_fpga_cmd_valid = 1'b0;
        end
        chk("cmp still_wait", leds, {1'b0, ST_WAIT});
        chk("cmp mode_stable", core_mode, code[0]);
        chk("cmp no_done", fpga_to_arm_done, 0);
        core_result = val;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        core_result = rand1024();
        m_result = val;
        chk("cmp result", fpga_to_arm_data, m_result);
        chk("cmp done_early", fpga_to_arm_done, 0);
        @(negedge clk);
        chk("cmp done_rise", fpga_to_arm_done, 1);
        chk("cmp one_start", start_cnt - s0, 1);
        ack("cmp");
        @(negedge clk);
        chk("cmp no_extra_done", fpga_to_arm_done, 0);
        check_regs("cmp after");
    endtask

    task automatic do_write(input int hold);
        $display("txn WRITE hold=%0d exp_lo=%h", hold, m_result[31:0]);
        send_cmd(32'd5);
        m_err = 1'b0;
        chk("wr leds_tx", leds, {1'b0, ST_TX});
        chk("wr valid_not_yet", fpga_to_arm_data_valid, 0);
        @(negedge clk);
        chk("wr valid_rise", fpga_to_arm_data_valid, 1);
        chk("wr data", fpga_to_arm_data, m_result);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("wr valid_hold", fpga_to_arm_data_valid, 1);
            chk("wr data_hold", fpga_to_arm_data, m_result);
        end
        fpga_to_arm_data_ready = 1'b1;
        @(negedge clk);
        fpga_to_arm_data_ready = 1'b0;
        chk("wr valid_fall", fpga_to_arm_data_valid, 0);
        chk("wr done_early", fpga_to_arm_done, 0);
        @(negedge clk);
        chk("wr done_rise", fpga_to_arm_done, 1);
        ack("wr");
    endtask

    task automatic do_unknown(input logic [31:0] c);
        $display("txn UNKNOWN code=%h", c);
        send_cmd(c);
        m_err = 1'b1;
        chk("unk leds", leds, {1'b1, ST_DONE});
        chk("unk done_early", fpga_to_arm_done, 0);
        @(negedge clk);
        chk("unk done_rise", fpga_to_arm_done, 1);
        chk("unk led_err", leds[3], 1);
        check_regs("unk");
        ack("unk");
    endtask

    task automatic pulse_reset(input string tag);
        $display("txn RESET %s", tag);
        resetn = 1'b0;
        #2;
        model_reset();
        check_all_zero(tag);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int op;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("por");
        resetn = 1'b1;
        @(negedge clk);
        chk("por leds_after", leds, 4'h0);

        // Reset aborting an RX, then a normal READ_MOD.
        send_cmd(32'd3);
        chk("midrx leds", leds, {1'b0, ST_RX});
        pulse_reset("mid_rx");
        do_read(2, rand1024(), 1);

        do_read(2, rand1024(), 0);
        do_read(3, rand1024(), 2);
        do_read(4, rand1024(), 3);

        do_compute(1, {512'd0, rand1024() >> 512}, 37, 1'b0);
        do_write(0);
        do_compute(0, {512'd0, rand1024() >> 512}, $urandom_range(10, 40), 1'b1);
        do_write(0);
        do_write(20);

        do_unknown(32'h7);
        chk("unk err_held", leds, 4'h8);
        do_read(2, rand1024(), 0);

        // Reset aborting a WAIT; a late core_done must land in IDLE and be ignored.
        send_cmd(32'd1);
        repeat (3) @(negedge clk);
        pulse_reset("mid_wait");
        core_result = rand1024();
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("late core_done result", fpga_to_arm_data, m_result);
        chk("late core_done leds", leds, 4'h0);
        chk("late core_done done", fpga_to_arm_done, 0);
        do_write(2);

        // Reset aborting a TX.
        send_cmd(32'd5);
        @(negedge clk);
        chk("midtx valid", fpga_to_arm_data_valid, 1);
        pulse_reset("mid_tx");

        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1, 2: do_read(op + 2, rand1024(), $urandom_range(0, 4));
                3:       do_compute($urandom_range(0, 1), rand1024(), $urandom_range(0, 40), 1'($urandom_range(0, 1)));
                4:       do_write($urandom_range(0, 5));
                default: do_unknown($urandom_range(6, 32'hffff));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_cmd_responder.md
# rsa_cmd_responder

FPGA-side command/handshake responder for the ARM-to-accelerator link of the RSA design. Decodes 32-bit ARM commands, accepts 1024-bit operand transfers into the modulus, R²/operand and exponent registers, launches the Montgomery core, returns the 1024-bit result, and holds `done` until ARM acknowledges. Sits between the ARM port bundle and the Montgomery/exponentiation datapath inside the RSA wrapper.

## Interface
- No parameters. Command codes are fixed: 0 COMPUTE_EXP, 1 COMPUTE_MONT, 2 READ_MOD, 3 READ_RSQ, 4 READ_EXP, 5 WRITE.
- `clk` in 1: single system clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `arm_to_fpga_cmd` in 32: command code.
- `arm_to_fpga_cmd_valid` in 1: command strobe.
- `fpga_to_arm_done` out 1: command complete; held until acknowledged.
- `fpga_to_arm_done_read` in 1: ARM acknowledge of done.
- `arm_to_fpga_data_valid` in 1: inbound data valid.
- `arm_to_fpga_data_ready` out 1: inbound data accepted (one-cycle pulse).
- `arm_to_fpga_data` in 1024: inbound data.
- `fpga_to_arm_data_valid` out 1: outbound data valid.
- `fpga_to_arm_data_ready` in 1: ARM ready for outbound data.
- `fpga_to_arm_data` out 1024: result register.
- `reg_mod`, `reg_rsq`, `reg_exp` out 1024 each: operand registers to the core.
- `core_start` out 1: one-cycle start pulse.
- `core_mode` out 1: 0 = exponentiation, 1 = Montgomery multiply. Stable while busy.
- `core_done` in 1: one-cycle completion pulse from the core.
- `core_result` in 1024: core result, valid while `core_done` is high.
- `leds` out 4: {err, state[2:0]}.

## Operation
- States: IDLE=0, RX=1, START=2, WAIT=3, TX=4, DONE=5.
- IDLE, `cmd_valid`=1. `cmd[31:0]` is decoded and `err` is cleared.
  - 2/3/4: latch the target register select and go to RX.
  - 0/1: set `core_mode` to `cmd[0]` and go to START.
  - 5: go to TX.
  - Any other code: set `err`=1, go directly to DONE, and change no register.
- RX: wait for `arm_to_fpga_data_valid`. On the first edge where it is sampled high:
  - capture `arm_to_fpga_data` into the selected register;
  - pulse `arm_to_fpga_data_ready` for exactly one cycle;
  - go to DONE.
- START: drive `core_start`=1 for this one cycle, then go to WAIT.
- WAIT: when `core_done` is sampled high, latch `core_result` into the result register (drives `fpga_to_arm_data`) and go to DONE.
- TX: `fpga_to_arm_data_valid`=1. When `fpga_to_arm_data_ready` is sampled high, the transfer is complete; drop valid and go to DONE.
- DONE: `fpga_to_arm_done`=1. When `done_read` is sampled high, go to IDLE.
- `cmd_valid` outside IDLE is ignored; the command is not queued.
- `data_valid` outside RX is ignored; no capture and no ready.
- `core_done` outside WAIT is ignored.
- The result register persists across commands. WRITE with no prior compute returns the last result, or 0 after reset.

## Timing
- All outputs are registered except `leds`, which is decoded from the state and `err` registers.
- Reset: state=IDLE, `err`=0, all 1024-bit registers=0, `core_mode`=0, and every strobe, valid, ready and done output = 0. The asynchronous assert aborts any operation immediately, including mid-RX, mid-WAIT and mid-TX. A later `core_done` then lands in IDLE and is ignored.
- `cmd_valid` sampled at edge N in IDLE → new state visible after N.
- `core_start` is high during cycle N+1 to N+2 for a compute.
- RX: `data_valid` sampled at edge K → register and `data_ready` updated after K; `done` rises after K+1; `data_ready` falls after K+1.
- WAIT: `core_done` sampled at edge K → result updated after K, `done` high after K+1.
- TX: valid rises one cycle after command decode. Data is stable from valid-rise until it falls; valid falls after the sampling edge of ready.
- DONE: `done_read` sampled at edge K → `done` low after K. A `cmd_valid` at the same edge K is ignored.
- Minimum command-to-done latency is 2 cycles: IDLE → DONE for an unknown code, then one cycle of done.

## Test plan
- Reset mid-RX: CMD 3, then pulse `resetn` low before data → all outputs 0 and `leds`=4'h0. A following CMD 2 works normally.
- READ_MOD / READ_RSQ / READ_EXP:
  - stimulus: send 1024'h8dc4…7e83, {512'hda8f…1372, 512'hdebc…e33c}, and 1024'h2685…a77b…af respectively;
  - required: each value appears only on its own `reg_*`;
  - required: `data_ready` is exactly one-cycle wide per transfer;
  - required: `done` stays high until `done_read`.
- COMPUTE_MONT:
  - stimulus: CMD 1; core model returns 512'h1ad6…1f33 zero-extended after 37 cycles;
  - required: `core_mode`=1 and exactly one `core_start` pulse;
  - then WRITE → `fpga_to_arm_data` equals the core value.
- COMPUTE_EXP:
  - stimulus: CMD 0, with the core returning 512'hbdb2…0189;
  - required: `core_mode`=0.
  - stimulus: a `cmd_valid` of CMD 2 while in WAIT;
  - required: it is ignored, no extra done is produced, and WRITE returns the expected value.
- WRITE with ready low:
  - stimulus: ready held low for 20 cycles;
  - required: valid and data stay stable throughout;
  - stimulus: ready raised;
  - required: valid drops and `done` rises the next cycle.
- Unknown CMD 32'h7: `done` rises with no register change and `leds[3]`=1. The next valid command clears `err`.
